// File: rtl/fma_issue_ctrl.sv
// fma_issue_ctrl: FMA issue stage with tagged input queue, sign-op operand prep,
// in-flight valid/tag pipe and a credit-protected response FIFO.
module fma_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int FMA_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_req_op,
    input  logic [31:0]      i_req_a,
    input  logic [31:0]      i_req_b,
    input  logic [31:0]      i_req_c,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic [31:0]      o_fma_a,
    output logic [31:0]      o_fma_b,
    output logic [31:0]      o_fma_c,
    input  logic [31:0]      i_fma_z,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_busy
);
    localparam int RSP_DEPTH = FMA_LAT + 2;
    localparam int QAW = $clog2(DEPTH);
    localparam int QCW = $clog2(DEPTH + 1);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int RCW = $clog2(RSP_DEPTH + 1);

    logic [1:0]       r_q_op  [DEPTH];
    logic [31:0]      r_q_a   [DEPTH];
    logic [31:0]      r_q_b   [DEPTH];
    logic [31:0]      r_q_c   [DEPTH];
    logic [TAG_W-1:0] r_q_tag [DEPTH];
    logic [QAW-1:0]   r_q_wr, r_q_rd;
    logic [QCW-1:0]   r_q_cnt;
    logic [RCW-1:0]   r_cred;
    logic [31:0]      r_fma_a, r_fma_b, r_fma_c;
    logic [FMA_LAT:0] r_pv;
    logic [FMA_LAT:0][TAG_W-1:0] r_pt;
    logic [31:0]      r_r_data [RSP_DEPTH];
    logic [TAG_W-1:0] r_r_tag  [RSP_DEPTH];
    logic [RAW-1:0]   r_r_wr, r_r_rd;
    logic [RCW-1:0]   r_r_cnt;

    logic             w_push, w_pop, w_issue, w_rsp_push;
    logic [TAG_W-1:0] w_tag;
    logic [RAW-1:0]   w_r_wr_nxt, w_r_rd_nxt;

    assign o_req_ready = r_q_cnt != QCW'(DEPTH);
    assign o_rsp_valid = r_r_cnt != '0;
    assign w_push      = i_req_valid && o_req_ready;
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    // A credit freed by this cycle's response pop may be spent by this cycle's issue,
    // which keeps full throughput once the credit loop is saturated.
    assign w_issue     = (r_q_cnt != '0) && (r_cred != '0 || w_pop);
    assign w_rsp_push  = r_pv[FMA_LAT];
    assign w_tag       = r_q_tag[r_q_rd];
    assign w_r_wr_nxt  = (r_r_wr == RAW'(RSP_DEPTH - 1)) ? '0 : r_r_wr + 1'b1;
    assign w_r_rd_nxt  = (r_r_rd == RAW'(RSP_DEPTH - 1)) ? '0 : r_r_rd + 1'b1;
    assign o_rsp_data  = r_r_data[r_r_rd];
    assign o_rsp_tag   = r_r_tag[r_r_rd];
    assign o_busy      = (r_q_cnt != '0) || (|r_pv) || o_rsp_valid;
    assign o_fma_a     = r_fma_a;
    assign o_fma_b     = r_fma_b;
    assign o_fma_c     = r_fma_c;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_op[r_q_wr]  <= i_req_op;
            r_q_a[r_q_wr]   <= i_req_a;
            r_q_b[r_q_wr]   <= i_req_b;
            r_q_c[r_q_wr]   <= i_req_c;
            r_q_tag[r_q_wr] <= i_req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_q_cnt <= '0;
            r_cred  <= RCW'(RSP_DEPTH);
            r_fma_a <= '0;
            r_fma_b <= '0;
            r_fma_c <= '0;
            r_pv    <= '0;
            r_pt    <= '0;
        end else begin
            if (w_push) r_q_wr <= r_q_wr + 1'b1;
            if (w_issue) begin
                r_q_rd  <= r_q_rd + 1'b1;
                r_fma_a <= r_q_a[r_q_rd] ^ {r_q_op[r_q_rd][1], 31'b0};
                r_fma_b <= r_q_b[r_q_rd];
                r_fma_c <= r_q_c[r_q_rd] ^ {r_q_op[r_q_rd][0], 31'b0};
            end
            r_q_cnt <= r_q_cnt + QCW'(w_push) - QCW'(w_issue);
            r_cred  <= r_cred - RCW'(w_issue) + RCW'(w_pop);
            r_pv    <= {r_pv[FMA_LAT-1:0], w_issue};
            r_pt    <= {r_pt[FMA_LAT-1:0], w_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_wr  <= '0;
            r_r_rd  <= '0;
            r_r_cnt <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_r_data[i] <= '0;
                r_r_tag[i]  <= '0;
            end
        end else begin
            if (w_rsp_push) begin
                r_r_data[r_r_wr] <= i_fma_z;
                r_r_tag[r_r_wr]  <= r_pt[FMA_LAT];
                r_r_wr           <= w_r_wr_nxt;
            end
            if (w_pop) r_r_rd <= w_r_rd_nxt;
            r_r_cnt <= r_r_cnt + RCW'(w_rsp_push) - RCW'(w_pop);
        end
    end
endmodule

// File: tb/tb_fma_issue_ctrl.sv
// tb_fma_issue_ctrl: directed bench for fma_issue_ctrl with a two-stage FMA stand-in.
module tb_fma_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid, o_req_ready;
    logic [1:0]  i_req_op;
    logic [31:0] i_req_a, i_req_b, i_req_c;
    logic [3:0]  i_req_tag;
    logic [31:0] o_fma_a, o_fma_b, o_fma_c, i_fma_z;
    logic        o_rsp_valid, i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic [3:0]  o_rsp_tag;
    logic        o_busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {logic [31:0] d; logic [3:0] t; int c;} rsp_t;
    rsp_t log_q[$];

    fma_issue_ctrl #(.DEPTH(4), .TAG_W(4), .FMA_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
        .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_c(i_req_c), .i_req_tag(i_req_tag),
        .o_fma_a(o_fma_a), .o_fma_b(o_fma_b), .o_fma_c(o_fma_c), .i_fma_z(i_fma_z),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_tag(o_rsp_tag), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // FMA stand-in: exact results for the 2*3+-1 sign cases, integer sum otherwise
    function automatic logic [31:0] fz(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (b == 32'h40400000 && a == 32'h40000000 && c == 32'h3F800000) return 32'h40E00000;
        if (b == 32'h40400000 && a == 32'h40000000 && c == 32'hBF800000) return 32'h40A00000;
        if (b == 32'h40400000 && a == 32'hC0000000 && c == 32'h3F800000) return 32'hC0A00000;
        if (b == 32'h40400000 && a == 32'hC0000000 && c == 32'hBF800000) return 32'hC0E00000;
        return a + b + c;
    endfunction

    logic [31:0] s1, s2;
    always @(posedge clk) begin
        s1 <= fz(o_fma_a, o_fma_b, o_fma_c);
        s2 <= s1;
    end
    assign i_fma_z = s2;

    // Handshake seen at negedge completes at the following posedge
    always @(negedge clk)
        if (rst_n && o_rsp_valid && i_rsp_ready) log_q.push_back('{d: o_rsp_data, t: o_rsp_tag, c: cyc});

    function automatic logic [31:0] va(input int i); return 32'h1000_0000 + i; endfunction
    function automatic logic [31:0] vb(input int i); return 32'h0000_0100 * i; endfunction
    function automatic logic [31:0] exp_z(input int i); return va(i) + vb(i) + 32'h0003_0000; endfunction

    task automatic set_vec(input int i, input logic [3:0] tag);
        i_req_op  = 2'b00;
        i_req_a   = va(i);
        i_req_b   = vb(i);
        i_req_c   = 32'h0003_0000;
        i_req_tag = tag;
    endtask

    task automatic do_single(input logic [1:0] op, input logic [3:0] tag,
                             output int lat, output logic [31:0] d, output logic [3:0] t);
        i_req_op = op; i_req_a = 32'h40000000; i_req_b = 32'h40400000;
        i_req_c = 32'h3F800000; i_req_tag = tag;
        i_rsp_ready = 1'b1; i_req_valid = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        lat = -1; d = '0; t = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (o_rsp_valid) begin
                lat = k; d = o_rsp_data; t = o_rsp_tag;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_stalled();
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_vec(i, 4'(i));
            i_req_valid = 1'b1;
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", o_req_ready); end
        n_chk++; if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", o_rsp_valid); end
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
        n_chk++; if ({o_rsp_data, o_rsp_tag} !== 36'h0) begin n_fail++; $display("FAIL reset_rsp got %h/%h want 0/0", o_rsp_data, o_rsp_tag); end
        n_chk++; if ({o_fma_a, o_fma_b, o_fma_c} !== 96'h0) begin n_fail++; $display("FAIL reset_fma got %h %h %h want 0", o_fma_a, o_fma_b, o_fma_c); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (o_busy !== 1'b0 || o_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle got busy=%b ready=%b want 0/1", o_busy, o_req_ready); end
    endtask

    task automatic test_fmadd();
        int lat; logic [31:0] d; logic [3:0] t;
        do_single(2'b00, 4'd5, lat, d, t);
        n_chk++; if (lat != 4) begin n_fail++; $display("FAIL fmadd_latency got %0d want 4", lat); end
        n_chk++; if (d !== 32'h40E00000) begin n_fail++; $display("FAIL fmadd_data got %h want 40e00000", d); end
        n_chk++; if (t !== 4'd5) begin n_fail++; $display("FAIL fmadd_tag got %0d want 5", t); end
        n_chk++; if (o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fmadd_drained got busy=%b valid=%b want 0/0", o_busy, o_rsp_valid); end
    endtask

    task automatic test_ops();
        int lat; logic [31:0] d; logic [3:0] t;
        do_single(2'b01, 4'd6, lat, d, t);
        n_chk++; if (d !== 32'h40A00000 || t !== 4'd6) begin n_fail++; $display("FAIL fmsub got %h/%0d want 40a00000/6", d, t); end
        n_chk++; if (o_fma_a !== 32'h40000000 || o_fma_c !== 32'hBF800000) begin n_fail++; $display("FAIL fmsub_operands got a=%h c=%h want 40000000/bf800000", o_fma_a, o_fma_c); end
        do_single(2'b11, 4'd7, lat, d, t);
        n_chk++; if (d !== 32'hC0E00000 || t !== 4'd7) begin n_fail++; $display("FAIL fnmadd got %h/%0d want c0e00000/7", d, t); end
        do_single(2'b10, 4'd8, lat, d, t);
        n_chk++; if (d !== 32'hC0A00000 || t !== 4'd8) begin n_fail++; $display("FAIL fnmsub got %h/%0d want c0a00000/8", d, t); end
        n_chk++; if (o_fma_a !== 32'hC0000000 || o_fma_b !== 32'h40400000 || o_fma_c !== 32'h3F800000) begin
            n_fail++; $display("FAIL fnmsub_operands got %h %h %h want c0000000 40400000 3f800000", o_fma_a, o_fma_b, o_fma_c); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        log_q.delete();
        fill_stalled();
        n_chk++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_queue_full got ready=%b want 0", o_req_ready); end
        n_chk++; if (o_fma_a !== va(3)) begin n_fail++; $display("FAIL bp_four_issued got fma_a=%h want %h", o_fma_a, va(3)); end
        n_chk++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== exp_z(0) || o_rsp_tag !== 4'd0) begin
            n_fail++; $display("FAIL bp_head got v=%b %h/%0d want 1 %h/0", o_rsp_valid, o_rsp_data, o_rsp_tag, exp_z(0)); end
        held = o_rsp_data;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (o_rsp_data !== held || o_rsp_tag !== 4'd0) begin n_fail++; $display("FAIL bp_stable got %h/%0d want %h/0", o_rsp_data, o_rsp_tag, held); end
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 40 && log_q.size() < 8; k++) @(posedge clk);
        #1;
        n_chk++; if (log_q.size() != 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", log_q.size()); end
        for (int i = 0; i < log_q.size() && i < 8; i++) begin
            n_chk++; if (log_q[i].t !== 4'(i) || log_q[i].d !== exp_z(i)) begin
                n_fail++; $display("FAIL bp_order[%0d] got %h/%0d want %h/%0d", i, log_q[i].d, log_q[i].t, exp_z(i), i); end
        end
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle got busy=%b want 0", o_busy); end
    endtask

    task automatic test_back_to_back();
        int drop = 0;
        log_q.delete();
        i_rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_vec(i + 20, 4'(i));
            i_req_valid = 1'b1;
            if (!o_req_ready) drop++;
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0;
        for (int k = 0; k < 30 && log_q.size() < 16; k++) @(posedge clk);
        #1;
        n_chk++; if (drop != 0) begin n_fail++; $display("FAIL b2b_ready_drop got %0d drops want 0", drop); end
        n_chk++; if (log_q.size() != 16) begin n_fail++; $display("FAIL b2b_count got %0d want 16", log_q.size()); end
        for (int i = 0; i < log_q.size() && i < 16; i++) begin
            n_chk++; if (log_q[i].t !== 4'(i) || log_q[i].d !== exp_z(i + 20)) begin
                n_fail++; $display("FAIL b2b_order[%0d] got %h/%0d want %h/%0d", i, log_q[i].d, log_q[i].t, exp_z(i + 20), i); end
        end
        if (log_q.size() == 16) begin
            n_chk++; if (log_q[15].c - log_q[0].c != 15) begin n_fail++; $display("FAIL b2b_consecutive got span %0d want 15", log_q[15].c - log_q[0].c); end
        end
    endtask

    task automatic test_full_pop();
        log_q.delete();
        fill_stalled();
        n_chk++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL fp_full got ready=%b want 0", o_req_ready); end
        set_vec(8, 4'd8);
        i_req_valid = 1'b1;
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL fp_ready_after_pop got %b want 1", o_req_ready); end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        for (int k = 0; k < 40; k++) @(posedge clk);
        #1;
        n_chk++; if (log_q.size() != 9) begin n_fail++; $display("FAIL fp_count got %0d want 9", log_q.size()); end
        for (int i = 0; i < log_q.size() && i < 9; i++) begin
            n_chk++; if (log_q[i].t !== 4'(i) || log_q[i].d !== exp_z(i)) begin
                n_fail++; $display("FAIL fp_order[%0d] got %h/%0d want %h/%0d", i, log_q[i].d, log_q[i].t, exp_z(i), i); end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] d; logic [3:0] t;
        log_q.delete();
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_vec(i, 4'(i));
            i_req_valid = 1'b1;
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_immediate got valid=%b busy=%b want 0/0", o_rsp_valid, o_busy); end
        n_chk++; if (o_req_ready !== 1'b1 || o_fma_a !== 32'h0) begin n_fail++; $display("FAIL rst_mid_state got ready=%b fma_a=%h want 1/0", o_req_ready, o_fma_a); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) @(posedge clk);
        #1;
        n_chk++; if (log_q.size() != 0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_rsp got %0d rsps busy=%b want 0/0", log_q.size(), o_busy); end
        do_single(2'b00, 4'd9, lat, d, t);
        n_chk++; if (lat != 4 || d !== 32'h40E00000 || t !== 4'd9) begin
            n_fail++; $display("FAIL rst_mid_recover got lat=%0d %h/%0d want 4 40e00000/9", lat, d, t); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        i_req_valid = 1'b0; i_rsp_ready = 1'b0; i_req_op = 2'b00;
        i_req_a = '0; i_req_b = '0; i_req_c = '0; i_req_tag = '0;
        test_reset();
        test_fmadd();
        test_ops();
        test_backpressure();
        test_back_to_back();
        test_full_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
